pwm_multi: RTL

- Parametrised multi-channel PWM generator; next generation of the single-channel configurable-speed PWM block.
- One shared period counter with a power-of-two prescaler drives CHANNELS independent duty comparators.
- Duty and period values are double-buffered and take effect only at period boundaries, so outputs never glitch.
- Sits behind the TinyTapeout top wrapper: ui_in/uio_in feed the configuration, uo_out carries the pwm outputs.

---
 rtl/pwm_multi_if.sv | 28 ++
 rtl/pwm_multi.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pwm_multi_if.sv
// Configuration/write bus and PWM outputs of pwm_multi; the controller drives
// the master side, the PWM block sits on the slave side.
interface pwm_multi_if #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 3
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  enable;
  logic [PRESCALE_W-1:0] speed;
  logic [WIDTH-1:0]      period;
  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [WIDTH-1:0]      wr_duty;
  logic [CHANNELS-1:0]   pwm;
  logic                  period_end;

  modport master (
    output enable, speed, period, wr_en, wr_ch, wr_duty,
    input  pwm, period_end
  );

  modport slave (
    input  enable, speed, period, wr_en, wr_ch, wr_duty,
    output pwm, period_end
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one prescaled period counter, double-buffered duty/period.
// Define PWM_MULTI_CENTER_EN for centre-aligned (up/down) counting.
module pwm_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  pwm_multi_if.slave bus
);
  localparam int PS_W = (1 << PRESCALE_W) - 1;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W:0]      CH_LIM  = (CH_W + 1)'(CHANNELS);
  localparam logic [PS_W-1:0]    PS_ONE  = PS_W'(1);
  localparam logic [WIDTH-1:0]   CNT_ONE = WIDTH'(1);

  logic [PS_W-1:0]     presc_r;
  logic [PS_W-1:0]     presc_term_s;
  logic [WIDTH-1:0]    cnt_r;
  logic [WIDTH-1:0]    cnt_nxt_s;
  logic [WIDTH-1:0]    period_act_r;
  logic [WIDTH-1:0]    duty_stg_r [CHANNELS];
  logic [WIDTH-1:0]    duty_act_r [CHANNELS];
  logic [CHANNELS-1:0] pwm_r;
  logic                period_end_r;
  logic                tick_s;
  logic                wrap_s;
  logic                wr_ok_s;
`ifdef PWM_MULTI_CENTER_EN
  logic                dir_down_r;
  logic                dir_down_nxt_s;
`endif

  // Terminal value wraps to all-ones when speed selects the widest divide.
  assign presc_term_s   = (PS_ONE << bus.speed) - PS_ONE;
  assign tick_s         = (presc_r == presc_term_s);
  assign wr_ok_s        = bus.wr_en && ({1'b0, bus.wr_ch} < CH_LIM);
  assign bus.pwm        = pwm_r;
  assign bus.period_end = period_end_r;

  // Next count value and wrap detection for the selected counting mode.
  always_comb begin
    cnt_nxt_s = cnt_r;
    wrap_s    = 1'b0;
`ifdef PWM_MULTI_CENTER_EN
    dir_down_nxt_s = dir_down_r;
    if (dir_down_r && (cnt_r == '0)) begin
      wrap_s = tick_s;
      if (bus.period == '0) begin
        cnt_nxt_s      = '0;
        dir_down_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s      = CNT_ONE;
        dir_down_nxt_s = 1'b0;
      end
    end else if (dir_down_r) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else if (cnt_r == period_act_r) begin
      cnt_nxt_s      = cnt_r - CNT_ONE;
      dir_down_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
`else
    if (cnt_r == period_act_r) begin
      wrap_s    = tick_s;
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
`endif
  end

  // Duty staging registers; writes to non-existent channels are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) duty_stg_r[i] <= '0;
    end else if (wr_ok_s) begin
      duty_stg_r[bus.wr_ch] <= bus.wr_duty;
    end
  end

  // Prescaler, period counter, shadow loads and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r      <= '0;
      cnt_r        <= '0;
      period_act_r <= '0;
      pwm_r        <= '0;
      period_end_r <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty_act_r[i] <= '0;
`ifdef PWM_MULTI_CENTER_EN
      dir_down_r   <= 1'b1;
`endif
    end else if (!bus.enable) begin
      // Stopped: shadows track staging so new values apply as soon as enable rises.
      presc_r      <= '0;
      cnt_r        <= '0;
      period_act_r <= bus.period;
      pwm_r        <= '0;
      period_end_r <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty_act_r[i] <= duty_stg_r[i];
`ifdef PWM_MULTI_CENTER_EN
      dir_down_r   <= 1'b1;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) pwm_r[i] <= (cnt_r < duty_act_r[i]);
      period_end_r <= wrap_s;
      if (tick_s) begin
        presc_r <= '0;
        cnt_r   <= cnt_nxt_s;
`ifdef PWM_MULTI_CENTER_EN
        dir_down_r <= dir_down_nxt_s;
`endif
      end else begin
        presc_r <= presc_r + PS_ONE;
      end
      if (wrap_s) begin
        period_act_r <= bus.period;
        for (int i = 0; i < CHANNELS; i++) duty_act_r[i] <= duty_stg_r[i];
      end
    end
  end
endmodule
